resonance_tracker: RTL and testbench

//  Parametrised successor of the fixed 15-bit cutting-horn frequency tracker. Contains:
//  - DDS gate generator.
//  - V/I phase-mismatch detector.
//  - Perturb-and-observe minimum-phase integrator with clamping, lock detection and freeze-on-stop.

---
 rtl/resonance_tracker_if.sv | 25 ++
 rtl/resonance_tracker.sv | 269 ++++++++++++++++++++++++++
 tb/tb_resonance_tracker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/resonance_tracker_if.sv
// Host command / gate driver bundle for resonance_tracker.
// The master drives the command and comparator inputs; the slave is the tracker.
interface resonance_tracker_if #(
    parameter int INC_W = 15,
    parameter int PD_W  = 8
);
    logic [4:0]       Din;
    logic             I;
    logic             V;
    logic             Gate_HI;
    logic             Gate_LO;
    logic [INC_W-1:0] increment;
    logic [PD_W-1:0]  theta;
    logic             locked;

    modport master (
        output Din, I, V,
        input  Gate_HI, Gate_LO, increment, theta, locked
    );

    modport slave (
        input  Din, I, V,
        output Gate_HI, Gate_LO, increment, theta, locked
    );
endinterface

// File: rtl/resonance_tracker.sv
// DDS half-bridge gate generator with V/I phase-mismatch detector and perturb-and-observe
// minimum-phase tracking. Define DEADTIME_EN to insert DT_CYC clocks of dead time per gate edge.
module resonance_tracker #(
    parameter int ACC_W    = 24,
    parameter int INC_W    = 15,
    parameter int PD_W     = 8,
    parameter int DIV      = 8,
    parameter int AVG_CYC  = 32,
    parameter int PERT     = 64,
    parameter int KI_SH    = 1,
    parameter int SET_BASE = 12460,
    parameter int SET_STEP = 224,
    parameter int INC_MIN  = 12000,
    parameter int INC_MAX  = 17500,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_N   = 4
`ifdef DEADTIME_EN
    ,
    parameter int DT_CYC   = 40
`endif
) (
    input  logic                   clk40MHz,
    input  logic                   rst_n,
    resonance_tracker_if.slave     bus
);
    localparam int INT_W = INC_W + 2;
    localparam int SUM_W = INT_W + 2;
    localparam int DLT_W = PD_W + 1;
    localparam int CYC_W = $clog2(AVG_CYC + 1);
    localparam int LCK_W = $clog2(LOCK_N + 1);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam logic [PD_W-1:0]         PD_MAX   = {PD_W{1'b1}};
    localparam logic [INT_W-1:0]        INT_MIN_V = INT_W'(INC_MIN * 4);
    localparam logic [INT_W-1:0]        INT_MAX_V = INT_W'(INC_MAX * 4);
    localparam logic signed [SUM_W-1:0] SUM_MIN  = SUM_W'(INC_MIN * 4);
    localparam logic signed [SUM_W-1:0] SUM_MAX  = SUM_W'(INC_MAX * 4);

    typedef enum logic {HALF_LO = 1'b0, HALF_HI = 1'b1} half_t;

    logic              r_i_meta, r_i_sync, r_v_meta, r_v_sync;
    logic [INC_W-1:0]  r_sp, w_sp_nxt;
    logic              r_stop, w_stop_nxt;
    logic              r_sweep, w_sweep_nxt;
    logic [ACC_W-1:0]  r_phase;
    logic              r_gate_d;
    logic [DIV_W-1:0]  r_div;
    logic [PD_W-1:0]   r_cnt, w_cnt_nxt;
    logic [PD_W-1:0]   r_theta, w_theta_nxt;
    logic [PD_W-1:0]   r_theta_lo, w_tlo_nxt;
    half_t             r_half, w_half_nxt;
    logic [CYC_W-1:0]  r_cyc, w_cyc_nxt;
    logic [INT_W-1:0]  r_integ, w_integ_nxt, w_integ_clamp;
    logic [LCK_W-1:0]  r_lock_cnt, w_lcnt_nxt, w_lcnt_inc;
    logic              r_locked, w_locked_nxt;
    logic [INC_W-1:0]  r_inc, w_inc;
    logic              r_gate_hi, r_gate_lo, w_hi_nxt, w_lo_nxt;
    logic              w_gate, w_bnd, w_en, w_mis;
    logic signed [DLT_W-1:0] w_delta;
    logic [DLT_W-1:0]        w_abs;
    logic signed [SUM_W-1:0] w_step, w_sum;

    assign w_gate  = r_phase[ACC_W-1];
    assign w_bnd   = w_gate & ~r_gate_d;
    assign w_en    = (r_div == DIV_W'(DIV - 1));
    assign w_mis   = r_i_sync ^ r_v_sync;
    assign w_delta = $signed({1'b0, r_theta_lo}) - $signed({1'b0, r_theta});
    assign w_abs   = w_delta[DLT_W-1] ? DLT_W'(-w_delta) : DLT_W'(w_delta);
    assign w_step  = $signed({{(SUM_W-DLT_W){w_delta[DLT_W-1]}}, w_delta}) <<< KI_SH;
    assign w_sum   = $signed({2'b00, r_integ}) + w_step;
    assign w_lcnt_inc = (r_lock_cnt == LCK_W'(LOCK_N)) ? r_lock_cnt : r_lock_cnt + LCK_W'(1);

    assign bus.Gate_HI   = r_gate_hi;
    assign bus.Gate_LO   = r_gate_lo;
    assign bus.increment = r_inc;
    assign bus.theta     = r_theta;
    assign bus.locked    = r_locked;

    // Host command decode: setpoint, stop and sweep flags
    always_comb begin
        w_sp_nxt    = r_sp;
        w_stop_nxt  = r_stop;
        w_sweep_nxt = r_sweep;
        if (bus.Din <= 5'd20) begin
            w_sp_nxt = INC_W'(SET_BASE) + INC_W'(bus.Din) * INC_W'(SET_STEP);
        end else begin
            case (bus.Din)
                5'd21:   w_stop_nxt  = 1'b0;
                5'd22:   w_stop_nxt  = 1'b1;
                5'd23:   w_sweep_nxt = 1'b1;
                5'd24:   w_sweep_nxt = 1'b0;
                5'd25: begin
                    w_sp_nxt    = INC_W'(SET_BASE);
                    w_stop_nxt  = 1'b0;
                    w_sweep_nxt = 1'b1;
                end
                default: w_sp_nxt = r_sp;
            endcase
        end
    end

    // Mismatch counter; a sample landing on the boundary clock belongs to the new cycle
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_theta_nxt = r_theta;
        if (r_stop) begin
            w_cnt_nxt = r_cnt;
        end else if (w_bnd) begin
            w_theta_nxt = r_cnt;
            w_cnt_nxt   = (w_en & w_mis) ? PD_W'(1) : PD_W'(0);
        end else if (w_en & w_mis & (r_cnt != PD_MAX)) begin
            w_cnt_nxt = r_cnt + PD_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Integrator clamp, applied in the same clock as the evaluation
    always_comb begin
        if (w_sum < SUM_MIN) begin
            w_integ_clamp = INT_MIN_V;
        end else if (w_sum > SUM_MAX) begin
            w_integ_clamp = INT_MAX_V;
        end else begin
            w_integ_clamp = w_sum[INT_W-1:0];
        end
    end

    // Perturb-and-observe half-period sequencing, evaluation and lock tracking
    always_comb begin
        w_half_nxt   = r_half;
        w_cyc_nxt    = r_cyc;
        w_integ_nxt  = r_integ;
        w_tlo_nxt    = r_theta_lo;
        w_lcnt_nxt   = r_lock_cnt;
        w_locked_nxt = r_locked;
        if (r_sweep) begin
            w_half_nxt   = HALF_LO;
            w_cyc_nxt    = CYC_W'(0);
            w_integ_nxt  = {r_sp, 2'b00};
            w_lcnt_nxt   = LCK_W'(0);
            w_locked_nxt = 1'b0;
        end else if (r_stop) begin
            w_locked_nxt = 1'b0;
        end else if (w_bnd) begin
            if (r_cyc == CYC_W'(AVG_CYC - 1)) begin
                w_cyc_nxt = CYC_W'(0);
                case (r_half)
                    HALF_LO: begin
                        w_half_nxt = HALF_HI;
                        w_tlo_nxt  = r_theta;
                    end
                    HALF_HI: begin
                        w_half_nxt  = HALF_LO;
                        w_integ_nxt = w_integ_clamp;
                        if (w_abs <= DLT_W'(LOCK_TOL)) begin
                            w_lcnt_nxt   = w_lcnt_inc;
                            w_locked_nxt = (w_lcnt_inc == LCK_W'(LOCK_N));
                        end else begin
                            w_lcnt_nxt   = LCK_W'(0);
                            w_locked_nxt = 1'b0;
                        end
                    end
                    default: w_half_nxt = HALF_LO;
                endcase
            end else begin
                w_cyc_nxt = r_cyc + CYC_W'(1);
            end
        end else begin
            w_cyc_nxt = r_cyc;
        end
    end

    // Live increment: setpoint while sweeping, integrator plus perturbation while tracking
    always_comb begin
        if (r_sweep) begin
            w_inc = r_sp;
        end else if (r_half == HALF_HI) begin
            w_inc = r_integ[INT_W-1:2] + INC_W'(PERT);
        end else begin
            w_inc = r_integ[INT_W-1:2];
        end
    end

`ifdef DEADTIME_EN
    localparam int DT_W = $clog2(DT_CYC + 1);
    logic [DT_W-1:0] r_dt, w_dt_nxt;

    // Dead-time window restarted by every gate edge; stop overrides on the next clock
    always_comb begin
        w_dt_nxt = r_dt;
        if (w_gate ^ r_gate_d) begin
            w_dt_nxt = DT_W'(DT_CYC - 1);
            w_hi_nxt = 1'b0;
            w_lo_nxt = 1'b0;
        end else if (r_dt != DT_W'(0)) begin
            w_dt_nxt = r_dt - DT_W'(1);
            w_hi_nxt = 1'b0;
            w_lo_nxt = 1'b0;
        end else begin
            w_hi_nxt = ~w_stop_nxt & w_gate;
            w_lo_nxt = ~w_stop_nxt & ~w_gate;
        end
    end

    // Dead-time counter register
    always_ff @(posedge clk40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_dt <= DT_W'(0);
        end else begin
            r_dt <= w_dt_nxt;
        end
    end
`else
    // Complementary gate drive without dead time
    always_comb begin
        w_hi_nxt = ~w_stop_nxt & w_gate;
        w_lo_nxt = ~w_stop_nxt & ~w_gate;
    end
`endif

    // State registers; everything returns to its reset value as soon as rst_n drops
    always_ff @(posedge clk40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_i_meta   <= 1'b0;
            r_i_sync   <= 1'b0;
            r_v_meta   <= 1'b0;
            r_v_sync   <= 1'b0;
            r_sp       <= INC_W'(SET_BASE);
            r_stop     <= 1'b1;
            r_sweep    <= 1'b1;
            r_phase    <= ACC_W'(0);
            r_gate_d   <= 1'b0;
            r_div      <= DIV_W'(0);
            r_cnt      <= PD_W'(0);
            r_theta    <= PD_W'(0);
            r_theta_lo <= PD_W'(0);
            r_half     <= HALF_LO;
            r_cyc      <= CYC_W'(0);
            r_integ    <= INT_W'(SET_BASE * 4);
            r_lock_cnt <= LCK_W'(0);
            r_locked   <= 1'b0;
            r_inc      <= INC_W'(SET_BASE);
            r_gate_hi  <= 1'b0;
            r_gate_lo  <= 1'b0;
        end else begin
            r_i_meta   <= bus.I;
            r_i_sync   <= r_i_meta;
            r_v_meta   <= bus.V;
            r_v_sync   <= r_v_meta;
            r_sp       <= w_sp_nxt;
            r_stop     <= w_stop_nxt;
            r_sweep    <= w_sweep_nxt;
            r_phase    <= r_phase + ACC_W'(r_inc);
            r_gate_d   <= w_gate;
            r_div      <= w_en ? DIV_W'(0) : r_div + DIV_W'(1);
            r_cnt      <= w_cnt_nxt;
            r_theta    <= w_theta_nxt;
            r_theta_lo <= w_tlo_nxt;
            r_half     <= w_half_nxt;
            r_cyc      <= w_cyc_nxt;
            r_integ    <= w_integ_nxt;
            r_lock_cnt <= w_lcnt_nxt;
            r_locked   <= w_locked_nxt;
            r_inc      <= w_inc;
            r_gate_hi  <= w_hi_nxt;
            r_gate_lo  <= w_lo_nxt;
        end
    end
endmodule

// File: tb/tb_resonance_tracker.sv
// Directed bench for resonance_tracker; two gate cycles per half-period keep the run short,
// and INC_MAX=13584 exercises the integrator clamp.
module tb_resonance_tracker;
    logic clk40MHz = 1'b0;
    logic rst_n    = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk40MHz = ~clk40MHz;

    resonance_tracker_if #(.INC_W(15), .PD_W(8)) bus ();

    resonance_tracker #(.AVG_CYC(2), .INC_MAX(13584)) dut (
        .clk40MHz (clk40MHz),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk40MHz);
    endtask

    task automatic wait_rise(input int budget, output bit ok);
        logic prev;
        int   n;
        prev = bus.Gate_HI;
        ok   = 1'b0;
        n    = 0;
        while (!ok && n < budget) begin
            @(negedge clk40MHz);
            n++;
            if (bus.Gate_HI && !prev) ok = 1'b1;
            prev = bus.Gate_HI;
        end
    endtask

    task automatic wait_inc_change(input int budget, output int rises, output bit ok);
        logic [14:0] start;
        logic        prev;
        int          n;
        start = bus.increment;
        prev  = bus.Gate_HI;
        rises = 0;
        ok    = 1'b0;
        n     = 0;
        while (!ok && n < budget) begin
            @(negedge clk40MHz);
            n++;
            if (bus.Gate_HI && !prev) rises++;
            prev = bus.Gate_HI;
            if (bus.increment !== start) ok = 1'b1;
        end
    endtask

    // A run of 8k consecutive mismatching clocks contains exactly k detector samples
    task automatic drive_window(input int win);
        bus.I = 1'b1;
        bus.V = 1'b0;
        tick(win);
        bus.I = 1'b0;
    endtask

    task automatic run_half(input int win, input string tag);
        bit ok;
        int r;
        drive_window(win);
        wait_rise(3000, ok);
        chk({tag, "_rise"}, 32'(ok), 32'd1);
        chk({tag, "_theta"}, 32'(bus.theta), 32'(win / 8));
        drive_window(win);
        wait_inc_change(3000, r, ok);
        chk({tag, "_toggle"}, 32'(ok), 32'd1);
    endtask

    initial begin : stim
        bit ok;
        int rises;
        int n;
        int comp_err;
        int integ_m;
        logic prev;

        bus.Din = 5'd26;
        bus.I   = 1'b0;
        bus.V   = 1'b0;

        // T1 reset
        tick(3);
        chk("rst_gate_hi", 32'(bus.Gate_HI), 32'd0);
        chk("rst_gate_lo", 32'(bus.Gate_LO), 32'd0);
        chk("rst_increment", 32'(bus.increment), 32'd12460);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_theta", 32'(bus.theta), 32'd0);
        rst_n = 1'b1;
        tick(50);
        chk("stopped_gate_hi", 32'(bus.Gate_HI), 32'd0);
        chk("stopped_gate_lo", 32'(bus.Gate_LO), 32'd0);

        // T2 setpoint commands and running gates
        bus.Din = 5'd20;
        tick(3);
        chk("din20_increment", 32'(bus.increment), 32'd16940);
        bus.Din = 5'd5;
        tick(3);
        chk("din5_increment", 32'(bus.increment), 32'd13580);
        bus.Din = 5'd21;
        tick(1);
        bus.Din = 5'd26;
        wait_rise(3000, ok);
        chk("t2_first_rise", 32'(ok), 32'd1);
        n = 0; comp_err = 0; ok = 1'b0; prev = 1'b1;
        while (!ok && n < 3000) begin
            @(negedge clk40MHz);
            n++;
`ifdef DEADTIME_EN
            if (bus.Gate_HI && bus.Gate_LO) comp_err++;
`else
            if (bus.Gate_HI !== ~bus.Gate_LO) comp_err++;
`endif
            if (bus.Gate_HI && !prev) ok = 1'b1;
            prev = bus.Gate_HI;
        end
        checks++;
        assert (n == 1235 || n == 1236) else begin
            failures++;
            $error("FAIL gate_period observed=%0d expected=1235..1236", n);
        end
        chk("gate_complementary_errors", 32'(comp_err), 32'd0);

        // T3 tracking with I=V: alternation, zero delta, lock after the 4th evaluation
        bus.Din = 5'd24;
        for (int e = 1; e <= 4; e++) begin
            wait_inc_change(4000, rises, ok);
            chk("t3_to_hi_seen", 32'(ok), 32'd1);
            chk("t3_hi_increment", 32'(bus.increment), 32'd13644);
            if (e > 1) chk("t3_lo_half_cycles", 32'(rises), 32'd2);
            wait_inc_change(4000, rises, ok);
            chk("t3_to_lo_seen", 32'(ok), 32'd1);
            chk("t3_lo_increment", 32'(bus.increment), 32'd13580);
            chk("t3_hi_half_cycles", 32'(rises), 32'd2);
            chk("t3_locked", 32'(bus.locked), (e == 4) ? 32'd1 : 32'd0);
        end

        // T4 theta_lo=20, theta_hi=16: +8 per evaluation, clamped at 13584*4
        integ_m = 13580 * 4;
        for (int k = 0; k < 3; k++) begin
            run_half(160, "t4_lo");
            chk("t4_hi_increment", 32'(bus.increment), 32'(integ_m / 4 + 64));
            run_half(128, "t4_hi");
            integ_m = integ_m + 8;
            if (integ_m > 13584 * 4) integ_m = 13584 * 4;
            chk("t4_lo_increment", 32'(bus.increment), 32'(integ_m / 4));
            chk("t4_locked", 32'(bus.locked), 32'd0);
        end

        // T5 stop in the middle of a HI half, then resume
        run_half(160, "t5_lo");
        chk("t5_hi_increment", 32'(bus.increment), 32'd13648);
        drive_window(128);
        wait_rise(3000, ok);
        chk("t5_mid_rise", 32'(ok), 32'd1);
        chk("t5_mid_theta", 32'(bus.theta), 32'd16);
        tick(100);
        bus.Din = 5'd22;
        tick(1);
        chk("t5_stop_gate_hi", 32'(bus.Gate_HI), 32'd0);
        chk("t5_stop_gate_lo", 32'(bus.Gate_LO), 32'd0);
        tick(3000);
        chk("t5_frozen_increment", 32'(bus.increment), 32'd13648);
        chk("t5_frozen_theta", 32'(bus.theta), 32'd16);
        chk("t5_frozen_locked", 32'(bus.locked), 32'd0);
        chk("t5_frozen_gate_hi", 32'(bus.Gate_HI), 32'd0);
        bus.Din = 5'd21;
        tick(1);
        wait_inc_change(3000, rises, ok);
        chk("t5_resume_seen", 32'(ok), 32'd1);
        chk("t5_resume_cycles", 32'(rises), 32'd1);
        chk("t5_resume_increment", 32'(bus.increment), 32'd13584);

        // Asynchronous reset in the middle of a gate cycle
        bus.Din = 5'd26;
        drive_window(160);
        wait_rise(3000, ok);
        chk("t6_rise", 32'(ok), 32'd1);
        chk("t6_theta_before", 32'(bus.theta), 32'd20);
        tick(3);
        @(posedge clk40MHz);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gate_hi", 32'(bus.Gate_HI), 32'd0);
        chk("arst_gate_lo", 32'(bus.Gate_LO), 32'd0);
        chk("arst_increment", 32'(bus.increment), 32'd12460);
        chk("arst_theta", 32'(bus.theta), 32'd0);
        chk("arst_locked", 32'(bus.locked), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
